// File: rtl/consolite_pkg.sv
// rtl/consolite_pkg.sv - shared screen geometry, pixel request type and issue states
package consolite_pkg;

  localparam int SCREEN_W = 128;
  localparam int SCREEN_H = 96;

  typedef struct packed {
    logic [7:0] rgb;
    logic [7:0] x;
    logic [7:0] y;
  } pixel_req_t;

  typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel request FIFO with tail peek/rgb rewrite for coalescing
module pixel_fifo
  import consolite_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pixel_req_t    push_data,
  input  logic          pop,
  output pixel_req_t    head,
  output pixel_req_t    tail,
  input  logic          tail_wr,
  input  logic [7:0]    tail_rgb,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  pixel_req_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;

  assign tail_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end else if (tail_wr) begin
      mem[tail_ptr].rgb <= tail_rgb;
    end
  end

endmodule

// File: rtl/pixel_queue.sv
// rtl/pixel_queue.sv - buffers processor pixel writes and issues them to pixel_writer
module pixel_queue #(
  parameter int DEPTH    = 16,
  parameter int COALESCE = 1,
  parameter int SCREEN_W = consolite_pkg::SCREEN_W,
  parameter int SCREEN_H = consolite_pkg::SCREEN_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_rgb,
  input  logic [7:0]               in_x,
  input  logic [7:0]               in_y,
  output logic                     pixel_en,
  output logic [7:0]               pixel_rgb,
  output logic [7:0]               pixel_x,
  output logic [7:0]               pixel_y,
  input  logic                     pixel_wr_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle,
  output logic                     oob_err
);
  import consolite_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  pixel_req_t    head;
  pixel_req_t    tail;
  pixel_req_t    in_req;
  state_t        state;
  logic          full;
  logic          empty;
  logic          accept;
  logic          oob;
  logic          pop;
  logic          push;
  logic          coalesce;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;

  assign in_req     = '{rgb: in_rgb, x: in_x, y: in_y};
  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign oob        = ({1'b0, in_x} >= X_LIM) || ({1'b0, in_y} >= Y_LIM);
  assign pop        = boot_done && !empty && ((state == IDLE) || pixel_wr_done);

  // A lone entry leaving this cycle cannot absorb the new colour; push it instead.
  assign coalesce   = (COALESCE != 0) && accept && !oob && !empty &&
                      (tail.x == in_x) && (tail.y == in_y) &&
                      !(pop && (fifo_count == CW'(1)));
  assign push       = accept && !oob && !coalesce;
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign count      = fifo_count;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_req),
    .pop       (pop),
    .head      (head),
    .tail      (tail),
    .tail_wr   (coalesce),
    .tail_rgb  (in_rgb),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pixel_en  <= 1'b0;
      pixel_rgb <= '0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      idle      <= 1'b1;
      oob_err   <= 1'b0;
    end else begin
      if (accept && oob) oob_err <= 1'b1;
      idle <= !pop && ((state == IDLE) || pixel_wr_done) && (count_next == '0);
      case (state)
        IDLE: begin
          if (pop) begin
            pixel_rgb <= head.rgb;
            pixel_x   <= head.x;
            pixel_y   <= head.y;
            pixel_en  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (pixel_wr_done) begin
            if (pop) begin
              pixel_rgb <= head.rgb;
              pixel_x   <= head.x;
              pixel_y   <= head.y;
            end else begin
              pixel_en <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_queue.sv
// tb/tb_pixel_queue.sv - self-checking bench for pixel_queue (coalescing and plain instances)
module tb_pixel_queue;
  import consolite_pkg::*;

  localparam int DEPTH = 16;
  localparam int SW    = 128;
  localparam int SH    = 96;

  logic       clk;
  logic       rst;
  logic       boot_done;
  logic       in_valid;
  logic [7:0] in_rgb;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       pixel_wr_done;

  logic       pen  [2];
  logic [7:0] prgb [2];
  logic [7:0] px   [2];
  logic [7:0] py   [2];
  logic [4:0] cnt  [2];
  logic       rdy  [2];
  logic       idl  [2];
  logic       oerr [2];

  int checks;
  int failures;

  // Reference model: index 0 coalesces, index 1 does not.
  pixel_req_t mq [2][$];
  bit         busy [2];
  pixel_req_t cur  [2];
  bit         oobm [2];

  pixel_queue #(.DEPTH(DEPTH), .COALESCE(1)) u_coal (
    .clk(clk), .rst(rst), .boot_done(boot_done), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_rgb(in_rgb), .in_x(in_x), .in_y(in_y), .pixel_en(pen[0]), .pixel_rgb(prgb[0]),
    .pixel_x(px[0]), .pixel_y(py[0]), .pixel_wr_done(pixel_wr_done), .count(cnt[0]),
    .idle(idl[0]), .oob_err(oerr[0])
  );

  pixel_queue #(.DEPTH(DEPTH), .COALESCE(0)) u_plain (
    .clk(clk), .rst(rst), .boot_done(boot_done), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_rgb(in_rgb), .in_x(in_x), .in_y(in_y), .pixel_en(pen[1]), .pixel_rgb(prgb[1]),
    .pixel_x(px[1]), .pixel_y(py[1]), .pixel_wr_done(pixel_wr_done), .count(cnt[1]),
    .idle(idl[1]), .oob_err(oerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      busy[m] = 1'b0;
      oobm[m] = 1'b0;
      cur[m]  = '0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, settle 1 ns past the edge.
  task automatic tick(input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] rgb, input logic done);
    in_valid = v; in_x = x; in_y = y; in_rgb = rgb; pixel_wr_done = done;
    for (int m = 0; m < 2; m++) begin
      int n;
      bit pop_ok, acc, bad, coal;
      pixel_req_t r;
      n      = mq[m].size();
      pop_ok = boot_done && (n > 0) && (!busy[m] || done);
      acc    = v && (n < DEPTH);
      bad    = (int'(x) >= SW) || (int'(y) >= SH);
      coal   = acc && !bad && (m == 0) && (n > 0) && (mq[m][n-1].x == x) &&
               (mq[m][n-1].y == y) && !(pop_ok && n == 1);
      if (pop_ok) begin
        cur[m]  = mq[m].pop_front();
        busy[m] = 1'b1;
      end else if (busy[m] && done) begin
        busy[m] = 1'b0;
      end
      if (acc && bad) begin
        oobm[m] = 1'b1;
      end else if (coal) begin
        r = mq[m][mq[m].size()-1];
        r.rgb = rgb;
        mq[m][mq[m].size()-1] = r;
      end else if (acc) begin
        r.rgb = rgb; r.x = x; r.y = y;
        mq[m].push_back(r);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pixel_wr_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pen[0] !== 1'b0 || cnt[0] !== 5'd0 || idl[0] !== 1'b1 || oerr[0] !== 1'b0 ||
        rdy[0] !== 1'b1 || prgb[0] !== 8'd0 || px[0] !== 8'd0 || py[0] !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: en=%0b cnt=%0d idle=%0b oob=%0b rdy=%0b rgb=%0h x=%0d y=%0d, want 0 0 1 0 1 0 0 0",
               pen[0], cnt[0], idl[0], oerr[0], rdy[0], prgb[0], px[0], py[0]);
    end
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    boot_done = 1'b1;
    tick(1'b1, 8'd10, 8'd20, 8'hE0, 1'b0);
    checks++;
    if (pen[0] !== 1'b0 || cnt[0] !== 5'd1) begin
      failures++;
      $display("FAIL latency_push: en=%0b cnt=%0d, want en=0 cnt=1", pen[0], cnt[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b1 || px[0] !== 8'd10 || py[0] !== 8'd20 || prgb[0] !== 8'hE0 ||
        cnt[0] !== 5'd0 || idl[0] !== 1'b0) begin
      failures++;
      $display("FAIL latency_issue: en=%0b x=%0d y=%0d rgb=%0h cnt=%0d idle=%0b, want 1 10 20 e0 0 0",
               pen[0], px[0], py[0], prgb[0], cnt[0], idl[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (pen[0] !== 1'b0 || idl[0] !== 1'b1) begin
      failures++;
      $display("FAIL latency_done: en=%0b idle=%0b, want en=0 idle=1", pen[0], idl[0]);
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] cols [DEPTH];
    do_reset();
    boot_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cols[i] = 8'($urandom_range(0, 255));
      tick(1'b1, 8'(i), 8'(i + 2), cols[i], 1'b0);
    end
    tick(1'b1, 8'd50, 8'd50, 8'h55, 1'b0);
    checks++;
    if (rdy[0] !== 1'b0 || cnt[0] !== 5'd16 || pen[0] !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: rdy=%0b cnt=%0d en=%0b, want rdy=0 cnt=16 en=0", rdy[0], cnt[0], pen[0]);
    end
    boot_done = 1'b1;
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (pen[0] !== 1'b1 || px[0] !== 8'(i) || py[0] !== 8'(i + 2) || prgb[0] !== cols[i]) begin
        failures++;
        $display("FAIL drain_order[%0d]: en=%0b x=%0d y=%0d rgb=%0h, want 1 %0d %0d %0h",
                 i, pen[0], px[0], py[0], prgb[0], i, i + 2, cols[i]);
      end
      tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    end
    checks++;
    if (pen[0] !== 1'b0 || idl[0] !== 1'b1 || cnt[0] !== 5'd0) begin
      failures++;
      $display("FAIL drain_end: en=%0b idle=%0b cnt=%0d, want 0 1 0", pen[0], idl[0], cnt[0]);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    boot_done = 1'b1;
    tick(1'b1, 8'd1, 8'd1, 8'h33, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd5, 8'd5, 8'h01, 1'b0);
    tick(1'b1, 8'd5, 8'd5, 8'h02, 1'b0);
    checks++;
    if (cnt[0] !== 5'd1 || cnt[1] !== 5'd2) begin
      failures++;
      $display("FAIL coal_count: coal=%0d plain=%0d, want 1 2", cnt[0], cnt[1]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (pen[0] !== 1'b1 || prgb[0] !== 8'h02 || px[0] !== 8'd5 || pen[1] !== 1'b1 || prgb[1] !== 8'h01) begin
      failures++;
      $display("FAIL coal_issue: coal en=%0b rgb=%0h x=%0d plain en=%0b rgb=%0h, want 1 02 5 1 01",
               pen[0], prgb[0], px[0], pen[1], prgb[1]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (pen[0] !== 1'b0 || pen[1] !== 1'b1 || prgb[1] !== 8'h02) begin
      failures++;
      $display("FAIL coal_second: coal en=%0b plain en=%0b rgb=%0h, want 0 1 02", pen[0], pen[1], prgb[1]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    tick(1'b1, 8'd9, 8'd9, 8'h10, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(1'b1, 8'd7, 8'd7, 8'h20, 1'b0);
    tick(1'b1, 8'd7, 8'd7, 8'h30, 1'b1);
    checks++;
    if (cnt[0] !== 5'd1 || pen[0] !== 1'b1 || px[0] !== 8'd7 || prgb[0] !== 8'h20) begin
      failures++;
      $display("FAIL coal_pop_excl: cnt=%0d en=%0b x=%0d rgb=%0h, want 1 1 7 20", cnt[0], pen[0], px[0], prgb[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (pen[0] !== 1'b1 || px[0] !== 8'd7 || prgb[0] !== 8'h30) begin
      failures++;
      $display("FAIL coal_pop_next: en=%0b x=%0d rgb=%0h, want 1 7 30", pen[0], px[0], prgb[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
  endtask

  task automatic test_oob();
    do_reset();
    boot_done = 1'b0;
    tick(1'b1, 8'd128, 8'd0, 8'h11, 1'b0);
    tick(1'b1, 8'd0, 8'd96, 8'h22, 1'b0);
    checks++;
    if (cnt[0] !== 5'd0 || oerr[0] !== 1'b1) begin
      failures++;
      $display("FAIL oob_drop: cnt=%0d oob=%0b, want 0 1", cnt[0], oerr[0]);
    end
    tick(1'b1, 8'd127, 8'd95, 8'h33, 1'b0);
    checks++;
    if (cnt[0] !== 5'd1 || oerr[0] !== 1'b1) begin
      failures++;
      $display("FAIL oob_sticky: cnt=%0d oob=%0b, want 1 1", cnt[0], oerr[0]);
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    boot_done = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(20 + i), 8'd3, 8'(i), 1'b0);
    boot_done = 1'b1;
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b1 || cnt[0] !== 5'd5) begin
      failures++;
      $display("FAIL rstbusy_pre: en=%0b cnt=%0d, want 1 5", pen[0], cnt[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pen[0] !== 1'b0 || cnt[0] !== 5'd0 || idl[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstbusy_async: en=%0b cnt=%0d idle=%0b, want 0 0 1", pen[0], cnt[0], idl[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b0 || idl[0] !== 1'b1 || cnt[0] !== 5'd0) begin
      failures++;
      $display("FAIL rstbusy_stray: en=%0b idle=%0b cnt=%0d, want 0 1 0", pen[0], idl[0], cnt[0]);
    end
  endtask

  task automatic test_boot_drop();
    do_reset();
    boot_done = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(40 + i), 8'd8, 8'(i), 1'b0);
    boot_done = 1'b1;
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    boot_done = 1'b0;
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b1 || cnt[0] !== 5'd3 || px[0] !== 8'd40) begin
      failures++;
      $display("FAIL bootdrop_hold: en=%0b cnt=%0d x=%0d, want 1 3 40", pen[0], cnt[0], px[0]);
    end
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b0 || cnt[0] !== 5'd3 || idl[0] !== 1'b0) begin
      failures++;
      $display("FAIL bootdrop_stall: en=%0b cnt=%0d idle=%0b, want 0 3 0", pen[0], cnt[0], idl[0]);
    end
    boot_done = 1'b1;
    tick(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (pen[0] !== 1'b1 || cnt[0] !== 5'd2 || px[0] !== 8'd41) begin
      failures++;
      $display("FAIL bootdrop_resume: en=%0b cnt=%0d x=%0d, want 1 2 41", pen[0], cnt[0], px[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] rx, ry;
    do_reset();
    boot_done = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 49) == 0) boot_done = !boot_done;
      rx = ($urandom_range(0, 39) == 0) ? 8'd128 : 8'($urandom_range(0, 3));
      ry = ($urandom_range(0, 39) == 0) ? 8'd96  : 8'($urandom_range(0, 2));
      tick(($urandom_range(0, 9) < 6), rx, ry, 8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 3));
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (pen[m] !== busy[m] || cnt[m] !== 5'(mq[m].size()) ||
            idl[m] !== (!busy[m] && mq[m].size() == 0) || oerr[m] !== oobm[m] ||
            rdy[m] !== (mq[m].size() < DEPTH)) begin
          failures++;
          $display("FAIL rnd_status[%0d] cyc %0d: en=%0b cnt=%0d idle=%0b oob=%0b rdy=%0b, want %0b %0d %0b %0b %0b",
                   m, c, pen[m], cnt[m], idl[m], oerr[m], rdy[m], busy[m], mq[m].size(),
                   (!busy[m] && mq[m].size() == 0), oobm[m], (mq[m].size() < DEPTH));
        end
        if (busy[m]) begin
          checks++;
          if (prgb[m] !== cur[m].rgb || px[m] !== cur[m].x || py[m] !== cur[m].y) begin
            failures++;
            $display("FAIL rnd_pixel[%0d] cyc %0d: rgb=%0h x=%0d y=%0d, want %0h %0d %0d",
                     m, c, prgb[m], px[m], py[m], cur[m].rgb, cur[m].x, cur[m].y);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    boot_done = 1'b0;
    in_valid = 1'b0;
    in_rgb = '0;
    in_x = '0;
    in_y = '0;
    pixel_wr_done = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_latency();
    test_fill_drain();
    test_coalesce();
    test_oob();
    test_reset_busy();
    test_boot_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
